joyport_conditioner: RTL
========================

JOYPORT_CONDITIONER -- requirements
Module: joyport_conditioner

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, meaning number of joystick ports, legal range 1..4.
REQ-002 SHALL have parameter PORT_BITS, default 5, meaning lines per port, ordered {fire, left, right, down, up} for the default of 5.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536, meaning the number of clk cycles an input must be stable before it is accepted; minimum 2.
REQ-004 SHALL have parameter AUTOFIRE_HALF, default 2000000, meaning the autofire half-period in clk cycles.
REQ-005 SHALL have port clk, input, width 1, meaning the system clock.
REQ-006 SHALL have port rst_n, input, width 1; one clock; reset is asynchronous and active-low.
REQ-007 SHALL have port joy_pin_n, input, width NUM_PORTS*PORT_BITS, meaning raw active-low pins, asynchronous to clk; port p occupies slice [p*PORT_BITS +: PORT_BITS].
REQ-008 SHALL have port autofire_en, input, width NUM_PORTS, meaning per-port autofire request.
REQ-009 SHALL have port joy, output, width NUM_PORTS*PORT_BITS, meaning debounced active-high state.
REQ-010 SHALL have port joy_changed, output, width 1, meaning a one-cycle strobe on any change of joy.

Function
REQ-011 SHALL pass every pin through a 2-flop synchroniser, then invert it so that internal logic is active-high.
REQ-012 SHALL keep one stable bit and one counter of $clog2(DEBOUNCE_CYCLES) bits per line.
REQ-013 SHALL clear the counter in any cycle where the synchronised value equals the stable bit.
REQ-014 SHALL increment the counter while the synchronised value differs from the stable bit; at DEBOUNCE_CYCLES-1 it SHALL update the stable bit and clear the counter in the same cycle.
REQ-015 SHALL restart the count from 0 on any bounce, i.e. a single-cycle return to the stable value.
REQ-016 SHALL give a pin-to-joy latency of exactly 2+DEBOUNCE_CYCLES clk cycles for a clean edge.
REQ-017 SHALL compute the autofire fire bit (bit PORT_BITS-1 of each port) as stable_fire AND phase when autofire is active; otherwise the fire bit SHALL equal stable_fire.
REQ-018 SHALL give each port a phase counter of $clog2(AUTOFIRE_HALF) bits; phase starts at 1 on the cycle stable_fire rises and toggles every AUTOFIRE_HALF cycles while held.
REQ-019 SHALL reset the counter to 0 and phase to 1 when fire is released or autofire_en drops, in the same cycle.
REQ-020 SHALL sample autofire_en each cycle; asserting it mid-hold SHALL start the phase at 1 in the following cycle.
REQ-021 SHALL register joy; joy_changed SHALL be high for exactly the cycle in which registered joy differs from its previous value, including autofire toggles.
REQ-022 SHALL update simultaneously changing lines on different ports independently with no arbitration.

Reset
REQ-023 SHALL, while rst_n is low: set synchroniser flops to 1 (idle pin), stable bits to 0, all counters to 0, phase to 1, joy to 0 and joy_changed to 0.
REQ-024 SHALL produce no joy_changed pulse on reset release with idle pins.
REQ-025 SHALL abandon any count in progress on reset mid-debounce, with no partial acceptance afterwards.

Configuration
REQ-026 SHALL compile the autofire logic only when macro JOYPORT_AUTOFIRE_EN is defined.
REQ-027 SHALL, without JOYPORT_AUTOFIRE_EN, ignore autofire_en (port retained), make the fire bit equal stable_fire, and instantiate no phase counters.

Structure
REQ-028 SHALL place the line-index constants (JOY_UP, JOY_DOWN, JOY_RIGHT, JOY_LEFT, JOY_FIRE) and the default PORT_BITS in shared package mega99_joy_pkg.
REQ-029 SHALL implement the per-line synchroniser plus debounce in sub-module joyport_debounce, instantiated NUM_PORTS*PORT_BITS times.

Verification
REQ-030 SHALL be checked with DEBOUNCE_CYCLES=4 and up pin of port 0 driven low at cycle 10: joy[0] rises at cycle 16; joy_changed is high at cycle 16 only.
REQ-031 SHALL be checked with DEBOUNCE_CYCLES=4 and up pin pulsed low for 3 cycles: joy stays 0 and no joy_changed pulse occurs.
REQ-032 SHALL be checked with DEBOUNCE_CYCLES=4 and a bounce pattern low,low,high,low,low,low,low: acceptance occurs 6 cycles after the last high.
REQ-033 SHALL be checked with AUTOFIRE_HALF=3, macro defined, fire held and autofire_en=1: the fire bit toggles 1,1,1,0,0,0,1 and joy_changed pulses at each toggle.
REQ-034 SHALL be checked with the macro undefined under the same stimulus as REQ-033: the fire bit stays 1 continuously.
REQ-035 SHALL be checked with rst_n asserted at counter value 2: joy and all counters read 0 after release, and the pin held low is accepted 6 cycles after release.

Source files
------------

// File: rtl/mega99_joy_pkg.sv
// Shared joystick definitions: line indices within a port and the default line count.
package mega99_joy_pkg;

  localparam int JOY_UP        = 0;
  localparam int JOY_DOWN      = 1;
  localparam int JOY_RIGHT     = 2;
  localparam int JOY_LEFT      = 3;
  localparam int JOY_FIRE      = 4;
  localparam int JOY_PORT_BITS = 5;

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/joyport_debounce.sv
// One joystick line: 2-flop synchroniser, inversion to active-high, and a
// stability counter that accepts a new level after DEBOUNCE_CYCLES agreeing samples.
module joyport_debounce
  import mega99_joy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_n,
  output logic stable
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]      sync_q;
  logic            sync_val;
  logic [DB_W-1:0] cnt;

  // Synchroniser idles high so an unplugged port reads as released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pin_n};
    end
  end

  assign sync_val = ~sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (sync_val == stable) begin
      cnt <= '0;
    end else if (cnt == DB_LAST) begin
      stable <= sync_val;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/joyport_conditioner.sv
// Debounces NUM_PORTS joystick ports and registers the result with a change strobe.
// Autofire on the fire line is compiled in only when JOYPORT_AUTOFIRE_EN is defined.
module joyport_conditioner
  import mega99_joy_pkg::*;
#(
  parameter int NUM_PORTS       = 2,
  parameter int PORT_BITS       = JOY_PORT_BITS,
  parameter int DEBOUNCE_CYCLES = 65536,
  parameter int AUTOFIRE_HALF   = 2000000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS*PORT_BITS-1:0] joy_pin_n,
  input  logic [NUM_PORTS-1:0]           autofire_en,
  output logic [NUM_PORTS*PORT_BITS-1:0] joy,
  output logic                           joy_changed
);

  localparam int LINES    = NUM_PORTS * PORT_BITS;
  localparam int FIRE_BIT = PORT_BITS - 1;

  logic [LINES-1:0] stable;
  logic [LINES-1:0] joy_next;

  for (genvar i = 0; i < LINES; i++) begin : g_line
    joyport_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .pin_n (joy_pin_n[i]),
      .stable(stable[i])
    );
  end

`ifdef JOYPORT_AUTOFIRE_EN
  localparam int AF_W = cnt_width(AUTOFIRE_HALF);
  localparam logic [AF_W-1:0] AF_LAST = AF_W'(AUTOFIRE_HALF - 1);

  logic [AF_W-1:0]      af_cnt [NUM_PORTS];
  logic [NUM_PORTS-1:0] phase;

  // Phase parks at 1 whenever autofire is idle, so fire passes straight through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        af_cnt[p] <= '0;
        phase[p]  <= 1'b1;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!stable[p*PORT_BITS+FIRE_BIT] || !autofire_en[p]) begin
          af_cnt[p] <= '0;
          phase[p]  <= 1'b1;
        end else if (af_cnt[p] == AF_LAST) begin
          af_cnt[p] <= '0;
          phase[p]  <= ~phase[p];
        end else begin
          af_cnt[p] <= af_cnt[p] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    joy_next = stable;
    for (int p = 0; p < NUM_PORTS; p++) begin
      joy_next[p*PORT_BITS+FIRE_BIT] = stable[p*PORT_BITS+FIRE_BIT] & phase[p];
    end
  end
`else
  logic unused_autofire_en;
  assign unused_autofire_en = ^autofire_en;

  always_comb begin
    joy_next = stable;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      joy         <= '0;
      joy_changed <= 1'b0;
    end else begin
      joy         <= joy_next;
      joy_changed <= |(joy_next ^ joy);
    end
  end

endmodule
